mem_stage_lsu: RTL and testbench

Next-generation memory-access stage between the execute stage and writeback. It replaces the purely combinational memory stage. Adds:
- req/ack handshake to the memory controller, with pipeline stall;
- byte-lane alignment and byte enables;
- misalignment detection;
- a bus-timeout error.
All outputs to writeback are registered, with a valid qualifier.

---
 rtl/mem_stage_lsu_pkg.sv | 58 +++++
 rtl/mem_stage_lsu_lane_align.sv | 50 +++++
 rtl/mem_stage_lsu.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-access stage: FSM states, opcodes,
// funct3 codes, byte-enable patterns and small lane helpers.
package mem_stage_lsu_pkg;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    function automatic logic [31:0] sign_extend8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    function automatic logic [31:0] zero_extend8(input logic [7:0] v);
        return {24'h0, v};
    endfunction

    function automatic logic [31:0] sign_extend16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zero_extend16(input logic [15:0] v);
        return {16'h0, v};
    endfunction

    // Stores only have B/H/W; loads add the unsigned B/H variants.
    function automatic logic func3_known(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    // Size is encoded in f3[1:0] for every known code: 00 byte, 01 half, 10 word.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering between the 32-bit bus and the core: store byte
// enables and replicated write data, plus load extraction with extension.
module mem_stage_lsu_lane_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  func_3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Store side: replicate data across lanes and enable only the target bytes.
    always_comb begin
        be_o    = BE_W;
        wdata_o = rs2_i;
        case (func_3_i[1:0])
            2'b00: begin
                be_o    = BE_B << addr_lo_i;
                wdata_o = {4{rs2_i[7:0]}};
            end
            2'b01: begin
                be_o    = BE_H << {addr_lo_i[1], 1'b0};
                wdata_o = {2{rs2_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane and extend to a full word.
    always_comb begin
        ldata_o = rdata_i;
        case (func_3_i)
            F3_B:    ldata_o = sign_extend8(byte_lane);
            F3_BU:   ldata_o = zero_extend8(byte_lane);
            F3_H:    ldata_o = sign_extend16(half_lane);
            F3_HU:   ldata_o = zero_extend16(half_lane);
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: issues one load/store at a time over a req/ack bus,
// stalls upstream while waiting, and registers every writeback output.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   LSU_IDLE | accepting; non-memory ops and faults complete in one cycle
//   LSU_BUSY | request outstanding; waiting for mem_ack or timeout
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [6:0]          i_opcode,
    input  logic [2:0]          i_func_3,
    input  logic [XLEN-1:0]     i_alu_out,
    input  logic [XLEN-1:0]     i_rs_2,
    input  logic [4:0]          i_rd_num,
    input  logic                i_op_type,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                o_valid,
    output logic [4:0]          rd_num,
    output logic [XLEN-1:0]     wb_data,
    output logic                op_type,
    output logic                misaligned,
    output logic                bus_err
);

    // Counter only has to reach TIMEOUT-1; width 1 keeps it legal when disabled.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit              TO_EN    = (TIMEOUT != 0);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        alo_q, alo_d;
    logic [4:0]        rd_lat_q, rd_lat_d;
    logic              opt_lat_q, opt_lat_d;
    logic              store_q, store_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [XLEN/8-1:0] mem_be_q, mem_be_d;

    logic              o_valid_q, o_valid_d;
    logic [4:0]        rd_num_q, rd_num_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              op_type_q, op_type_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_err_q, bus_err_d;

    logic              is_load, is_store, is_mem;
    logic [2:0]        lane_func3;
    logic [1:0]        lane_alo;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, lane_ldata;

    assign is_load  = (i_opcode == OP_LOAD);
    assign is_store = (i_opcode == OP_STORE);
    assign is_mem   = is_load || is_store;

    // IDLE steers fresh store lanes; BUSY extracts the load with latched fields.
    mem_stage_lsu_lane_align u_lane_align (
        .func_3_i  (lane_func3),
        .addr_lo_i (lane_alo),
        .rs2_i     (i_rs_2),
        .rdata_i   (mem_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .ldata_o   (lane_ldata)
    );

    // Next-state, request and writeback decisions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        func3_d      = func3_q;
        alo_d        = alo_q;
        rd_lat_d     = rd_lat_q;
        opt_lat_d    = opt_lat_q;
        store_d      = store_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        o_valid_d    = 1'b0;
        rd_num_d     = rd_num_q;
        wb_data_d    = wb_data_q;
        op_type_d    = op_type_q;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        stall        = 1'b0;
        lane_func3   = i_func_3;
        lane_alo     = i_alu_out[1:0];

        case (state_q)
            LSU_IDLE: begin
                if (i_valid) begin
                    o_valid_d = 1'b1;
                    op_type_d = i_op_type;
                    if (!is_mem || !func3_known(is_store, i_func_3)) begin
                        rd_num_d  = is_mem ? 5'd0 : i_rd_num;
                        wb_data_d = i_alu_out;
                    end else if (addr_misaligned(i_func_3, i_alu_out[1:0])) begin
                        misaligned_d = 1'b1;
                        rd_num_d     = 5'd0;
                        wb_data_d    = '0;
                    end else begin
                        o_valid_d   = 1'b0;
                        stall       = 1'b1;
                        state_d     = LSU_BUSY;
                        cnt_d       = '0;
                        func3_d     = i_func_3;
                        alo_d       = i_alu_out[1:0];
                        rd_lat_d    = i_rd_num;
                        opt_lat_d   = i_op_type;
                        store_d     = is_store;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {i_alu_out[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = lane_wdata;
                        mem_be_d    = lane_be;
                    end
                end
            end
            LSU_BUSY: begin
                lane_func3 = func3_q;
                lane_alo   = alo_q;
                stall      = !mem_ack;
                if (mem_ack || (TO_EN && (cnt_q == CNT_LAST))) begin
                    state_d     = LSU_IDLE;
                    cnt_d       = '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    o_valid_d   = 1'b1;
                    op_type_d   = opt_lat_q;
                    if (mem_ack && !store_q) begin
                        rd_num_d  = rd_lat_q;
                        wb_data_d = lane_ldata;
                    end else begin
                        rd_num_d  = 5'd0;
                        wb_data_d = '0;
                    end
                    bus_err_d = !mem_ack;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // State, latches and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            func3_q      <= '0;
            alo_q        <= '0;
            rd_lat_q     <= '0;
            opt_lat_q    <= 1'b0;
            store_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            o_valid_q    <= 1'b0;
            rd_num_q     <= '0;
            wb_data_q    <= '0;
            op_type_q    <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            func3_q      <= func3_d;
            alo_q        <= alo_d;
            rd_lat_q     <= rd_lat_d;
            opt_lat_q    <= opt_lat_d;
            store_q      <= store_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            o_valid_q    <= o_valid_d;
            rd_num_q     <= rd_num_d;
            wb_data_q    <= wb_data_d;
            op_type_q    <= op_type_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign o_valid    = o_valid_q;
    assign rd_num     = rd_num_q;
    assign wb_data    = wb_data_q;
    assign op_type    = op_type_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with TIMEOUT = 4.
module tb_mem_stage_lsu;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    logic        clk, rst;
    logic        i_valid, i_op_type;
    logic [6:0]  i_opcode;
    logic [2:0]  i_func_3;
    logic [31:0] i_alu_out, i_rs_2;
    logic [4:0]  i_rd_num;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        o_valid, op_type, misaligned, bus_err;
    logic [4:0]  rd_num;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_opcode   (i_opcode),
        .i_func_3   (i_func_3),
        .i_alu_out  (i_alu_out),
        .i_rs_2     (i_rs_2),
        .i_rd_num   (i_rd_num),
        .i_op_type  (i_op_type),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .o_valid    (o_valid),
        .rd_num     (rd_num),
        .wb_data    (wb_data),
        .op_type    (op_type),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
        i_valid   = v;
        i_opcode  = opc;
        i_func_3  = f3;
        i_alu_out = alu;
        i_rs_2    = rs2;
        i_rd_num  = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; i_op_type = 1'b0;
        drive(1'b0, OP_ADD, 3'b000, 32'h0, 32'h0, 5'd0);
        tick(); tick();
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_o_valid", {31'h0, o_valid}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        rst = 1'b0;
        tick();

        // ADD passthrough
        i_op_type = 1'b1;
        drive(1'b1, OP_ADD, 3'b000, 32'h1234, 32'h0, 5'd5);
        check("add_stall", {31'h0, stall}, 32'h0);
        tick();
        check("add_o_valid", {31'h0, o_valid}, 32'h1);
        check("add_wb_data", wb_data, 32'h1234);
        check("add_rd_num", {27'h0, rd_num}, 32'd5);
        check("add_op_type", {31'h0, op_type}, 32'h1);
        check("add_mem_req", {31'h0, mem_req}, 32'h0);
        i_op_type = 1'b0;
        drive(1'b0, OP_ADD, 3'b000, 32'h0, 32'h0, 5'd0);
        tick();
        check("idle_o_valid", {31'h0, o_valid}, 32'h0);

        // LB at 0x103, ack in the third BUSY cycle
        drive(1'b1, OP_LD, 3'b000, 32'h103, 32'h0, 5'd7);
        check("lb_accept_stall", {31'h0, stall}, 32'h1);
        tick();
        check("lb_mem_req", {31'h0, mem_req}, 32'h1);
        check("lb_mem_addr", mem_addr, 32'h100);
        check("lb_mem_we", {31'h0, mem_we}, 32'h0);
        check("lb_busy1_stall", {31'h0, stall}, 32'h1);
        tick();
        check("lb_busy2_stall", {31'h0, stall}, 32'h1);
        check("lb_busy2_o_valid", {31'h0, o_valid}, 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h80FF_EE11; #1;
        check("lb_ack_stall", {31'h0, stall}, 32'h0);
        tick();
        mem_ack = 1'b0;
        check("lb_o_valid", {31'h0, o_valid}, 32'h1);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_rd_num", {27'h0, rd_num}, 32'd7);
        check("lb_done_mem_req", {31'h0, mem_req}, 32'h0);

        // LBU back-to-back, ack in the first BUSY cycle (2-cycle latency)
        drive(1'b1, OP_LD, 3'b100, 32'h103, 32'h0, 5'd8);
        check("lbu_accept_stall", {31'h0, stall}, 32'h1);
        tick();
        mem_ack = 1'b1; #1;
        tick();
        mem_ack = 1'b0;
        check("lbu_o_valid", {31'h0, o_valid}, 32'h1);
        check("lbu_wb_data", wb_data, 32'h0000_0080);
        check("lbu_rd_num", {27'h0, rd_num}, 32'd8);

        // LH at 0x102 -> upper half 0x80FF sign-extended
        drive(1'b1, OP_LD, 3'b001, 32'h102, 32'h0, 5'd9);
        tick();
        mem_ack = 1'b1; #1;
        tick();
        mem_ack = 1'b0;
        check("lh_wb_data", wb_data, 32'hFFFF_80FF);

        // SH at 0x202
        drive(1'b1, OP_ST, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd9);
        tick();
        check("sh_mem_we", {31'h0, mem_we}, 32'h1);
        check("sh_mem_addr", mem_addr, 32'h200);
        check("sh_mem_be", {28'h0, mem_be}, 32'hC);
        check("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_ack = 1'b1; #1;
        tick();
        mem_ack = 1'b0;
        drive(1'b0, OP_ADD, 3'b000, 32'h0, 32'h0, 5'd0);
        check("sh_o_valid", {31'h0, o_valid}, 32'h1);
        check("sh_rd_num", {27'h0, rd_num}, 32'd0);
        check("sh_wb_data", wb_data, 32'h0);

        // LW at 0x301 -> misaligned, no request
        drive(1'b1, OP_LD, 3'b010, 32'h301, 32'h0, 5'd3);
        check("lw_mis_stall", {31'h0, stall}, 32'h0);
        tick();
        drive(1'b0, OP_ADD, 3'b000, 32'h0, 32'h0, 5'd0);
        check("lw_mis_mem_req", {31'h0, mem_req}, 32'h0);
        check("lw_mis_o_valid", {31'h0, o_valid}, 32'h1);
        check("lw_mis_flag", {31'h0, misaligned}, 32'h1);
        check("lw_mis_rd_num", {27'h0, rd_num}, 32'd0);

        // SW with no ack -> 4 request cycles then bus_err
        drive(1'b1, OP_ST, 3'b010, 32'h400, 32'h1234_5678, 5'd2);
        tick();
        check("sw_mem_be", {28'h0, mem_be}, 32'hF);
        check("sw_mem_wdata", mem_wdata, 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sw_to_req%0d", k), {31'h0, mem_req}, 32'h1);
            check($sformatf("sw_to_ov%0d", k), {31'h0, o_valid}, 32'h0);
            if (k == 3) drive(1'b0, OP_ADD, 3'b000, 32'h0, 32'h0, 5'd0);
            tick();
        end
        check("sw_to_o_valid", {31'h0, o_valid}, 32'h1);
        check("sw_to_bus_err", {31'h0, bus_err}, 32'h1);
        check("sw_to_mem_req", {31'h0, mem_req}, 32'h0);
        check("sw_to_rd_num", {27'h0, rd_num}, 32'd0);
        tick();
        mem_ack = 1'b1; #1;
        tick();
        mem_ack = 1'b0;
        check("late_ack_o_valid", {31'h0, o_valid}, 32'h0);
        check("late_ack_mem_req", {31'h0, mem_req}, 32'h0);

        // Ack on the expiry cycle wins: normal completion
        drive(1'b1, OP_ST, 3'b010, 32'h404, 32'h0, 5'd2);
        tick(); tick(); tick(); tick();
        mem_ack = 1'b1; i_valid = 1'b0; #1;
        tick();
        mem_ack = 1'b0;
        check("tie_o_valid", {31'h0, o_valid}, 32'h1);
        check("tie_bus_err", {31'h0, bus_err}, 32'h0);

        // Reset during the second BUSY cycle of an LW
        drive(1'b1, OP_LD, 3'b010, 32'h500, 32'h0, 5'd4);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, OP_ADD, 3'b000, 32'h0, 32'h0, 5'd0);
        check("rstbusy_mem_req", {31'h0, mem_req}, 32'h0);
        check("rstbusy_o_valid", {31'h0, o_valid}, 32'h0);
        mem_ack = 1'b1; #1;
        tick();
        mem_ack = 1'b0;
        check("rstbusy_ack_o_valid", {31'h0, o_valid}, 32'h0);
        drive(1'b1, OP_ADD, 3'b000, 32'hCAFE, 32'h0, 5'd4);
        tick();
        drive(1'b0, OP_ADD, 3'b000, 32'h0, 32'h0, 5'd0);
        check("post_rst_add_o_valid", {31'h0, o_valid}, 32'h1);
        check("post_rst_add_wb_data", wb_data, 32'hCAFE);
        check("post_rst_add_rd_num", {27'h0, rd_num}, 32'd4);

        // Unknown funct3 on LOAD -> no-op with rd 0, no request, no flags
        drive(1'b1, OP_LD, 3'b011, 32'h600, 32'h0, 5'd6);
        check("unk_stall", {31'h0, stall}, 32'h0);
        tick();
        drive(1'b0, OP_ADD, 3'b000, 32'h0, 32'h0, 5'd0);
        check("unk_o_valid", {31'h0, o_valid}, 32'h1);
        check("unk_rd_num", {27'h0, rd_num}, 32'd0);
        check("unk_mem_req", {31'h0, mem_req}, 32'h0);
        check("unk_misaligned", {31'h0, misaligned}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
